// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
// Shared constants and helpers for the CPU clock-enable generator.
//   CNT_W_DEFAULT : default width of the period counter (max period 2^CNT_W)
//   MIN_PERIOD_M1 : smallest legal period-1 (period 2). A requested value of
//                   0 is raised to this value.
//   half_len()    : length of the phi2-low half of a period, ceil(P/2)
// -----------------------------------------------------------------------------
package clkgen_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;
    localparam int unsigned MIN_PERIOD_M1 = 1;

    // Odd periods give the extra count to the low phase.
    function automatic int unsigned half_len(input int unsigned period);
        return (period + 1) / 2;
    endfunction

endpackage

// File: rtl/clkgen_strobe_div.sv
// -----------------------------------------------------------------------------
// clkgen_strobe_div
// Counts input strobes modulo N. It emits a registered output strobe in the
// same cycle as the registered copy of every N-th input strobe. Feed it the
// pre-register decode of a strobe, so its output lines up with that strobe's
// flop. N = 1 passes every strobe through.
// Ports:
//   clk      in  master clock
//   rst_n    in  synchronous active-low reset
//   i_strobe in  unregistered strobe condition to count
//   o_strobe out one-clk strobe on every N-th input strobe (flop output)
// -----------------------------------------------------------------------------
module clkgen_strobe_div #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_strobe
);

    localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic          r_strobe;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= i_strobe && w_last;
            if (i_strobe) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
// CPU clock-enable generator with a run-time programmable period. It produces:
//   - the Phi2 level
//   - one-clk phi1/phi2 enable strobes
//   - an optional slower aux enable for peripherals
// All outputs are flop outputs. They change one clk after the counter value
// that decodes them.
//
// Build option:
//   CLKGEN_AUX_EN defined   -> aux_en fires with every AUX_DIV-th phi2_en
//   CLKGEN_AUX_EN undefined -> no aux counter is built, aux_en is tied to 0
//
// Ports:
//   clk      in   master clock, rising edge
//   rst_n    in   synchronous active-low reset
//   div_sel  in   requested period-1 (0 is treated as 1); applied at wrap
//   hold     in   1 freezes the counter and the phase, and suppresses strobes
//   phi2     out  low for the first ceil(P/2) counts, high for the rest
//   phi1_en  out  strobe on the first cycle of phi2 low
//   phi2_en  out  strobe on the first cycle of phi2 high
//   aux_en   out  strobe on every AUX_DIV-th phi2_en
// -----------------------------------------------------------------------------
module clock_enable_gen
    import clkgen_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DIV_DEFAULT = 15,
    parameter int unsigned AUX_DIV     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_sel,
    input  logic             hold,
    output logic             phi2,
    output logic             phi1_en,
    output logic             phi2_en,
    output logic             aux_en
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_PERIOD_M1);
    localparam logic [CNT_W-1:0] RST_M1 = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_m1;
    logic             r_phi2;
    logic             r_phi1_en;
    logic             r_phi2_en;

    logic             w_advance;
    logic             w_wrap;
    logic             w_phi2_hit;
    logic [CNT_W-1:0] w_low_len;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_eff;

    assign w_advance  = !hold;
    assign w_wrap     = (r_cnt == r_per_m1);
    // ceil(P/2) is at most 2^(CNT_W-1), so it always fits back into CNT_W bits.
    assign w_low_len  = CNT_W'(half_len(32'(r_per_m1) + 32'd1));
    assign w_phi2_hit = (r_cnt == w_low_len - ONE);
    assign w_div_eff  = (div_sel < MIN_M1) ? MIN_M1 : div_sel;
    assign w_cnt_nxt  = !w_advance ? r_cnt :
                        w_wrap     ? '0    : r_cnt + ONE;

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_per_m1  <= RST_M1;
            r_phi2    <= 1'b0;
            r_phi1_en <= 1'b0;
            r_phi2_en <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            // The ratio is reloaded only at the boundary, so a running period
            // is never cut short.
            if (w_advance && w_wrap) begin
                r_per_m1 <= w_div_eff;
            end
            // At a wrap the next count is 0. That is below any low length,
            // so using the old period's low length here is safe. While held,
            // the next count equals the current one, so phi2 keeps its value.
            r_phi2    <= (w_cnt_nxt >= w_low_len);
            r_phi2_en <= w_advance && w_phi2_hit;
            r_phi1_en <= w_advance && w_wrap;
        end
    end

    assign phi2    = r_phi2;
    assign phi1_en = r_phi1_en;
    assign phi2_en = r_phi2_en;

`ifdef CLKGEN_AUX_EN
    clkgen_strobe_div #(
        .N (AUX_DIV)
    ) u_aux_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (w_advance && w_phi2_hit),
        .o_strobe (aux_en)
    );
`else
    // AUX_DIV stays in the parameter list, so both builds share one interface.
    logic w_unused_aux_div;
    assign w_unused_aux_div = (AUX_DIV >= 1);
    assign aux_en           = 1'b0;
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
// Directed bench for clock_enable_gen (CNT_W=4, DIV_DEFAULT=15, AUX_DIV=4).
// Each cycle it compares {phi2, phi1_en, phi2_en, aux_en} against expected
// values. Those values come from the period arithmetic. aux_en is expected
// only when the bench is built with CLKGEN_AUX_EN.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

`ifdef CLKGEN_AUX_EN
    localparam bit AUX_ON = 1'b1;
`else
    localparam bit AUX_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic [3:0] div_sel;
    logic       phi2;
    logic       phi1_en;
    logic       phi2_en;
    logic       aux_en;

    int n_pass  = 0;
    int n_total = 0;
    int n_p2en  = 0;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .CNT_W       (4),
        .DIV_DEFAULT (15),
        .AUX_DIV     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_sel (div_sel),
        .hold    (hold),
        .phi2    (phi2),
        .phi1_en (phi1_en),
        .phi2_en (phi2_en),
        .aux_en  (aux_en)
    );

    // Expected {phi2, phi1_en, phi2_en} k edges after reset release, period 16.
    function automatic logic [2:0] exp_default(input int k);
        int c;
        c = k % 16;
        return {c >= 8, (c == 0) && (k > 0), c == 8};
    endfunction

    // Expected {phi2, phi1_en, phi2_en} for period 2 or 5 at count j.
    function automatic logic [2:0] exp_period(input int j, input int lowlen);
        return {j >= lowlen, j == 0, j == lowlen};
    endfunction

    // aux_en is expected on every 4th expected phi2_en since reset.
    task automatic aux_model(input logic p2, output logic a);
        if (p2) n_p2en++;
        a = AUX_ON && p2 && (n_p2en % 4 == 0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] ds);
        rst_n   = 1'b0;
        hold    = 1'b0;
        div_sel = ds;
        step();
        rst_n  = 1'b1;
        n_p2en = 0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n   = 1'b0;
        hold    = 1'b0;
        div_sel = 4'd15;
        step();
        got = {phi2, phi1_en, phi2_en, aux_en};
        n_total++;
        if (got !== 4'b0000)
            $display("FAIL reset_state got=%b exp=0000", got);
        else
            n_pass++;
    endtask

    task automatic test_default_period();
        logic [2:0] e;
        logic       ea;
        logic [3:0] got;
        do_reset(4'd15);
        for (int k = 1; k <= 130; k++) begin
            step();
            e = exp_default(k);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL default_period k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
    endtask

    task automatic test_ratio_change();
        logic [2:0] e;
        logic       ea;
        logic [3:0] got;
        do_reset(4'd15);
        for (int k = 1; k <= 45; k++) begin
            if (k == 6) div_sel = 4'd4;
            step();
            e = (k < 16) ? exp_default(k) : exp_period((k - 16) % 5, 3);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL ratio_change k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
    endtask

    task automatic test_min_ratio();
        logic [2:0] e;
        logic       ea;
        logic [3:0] got;
        do_reset(4'd0);
        for (int k = 1; k <= 30; k++) begin
            step();
            e = (k < 16) ? exp_default(k) : exp_period((k - 16) % 2, 1);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL min_ratio k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [2:0] e;
        logic       ea;
        logic [3:0] got;
        do_reset(4'd15);
        for (int k = 1; k <= 40; k++) begin
            hold = (k >= 8) && (k <= 17);
            step();
            if (k <= 7)       e = exp_default(k);
            else if (k <= 17) e = 3'b000;
            else              e = exp_default(k - 10);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL hold k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid_high();
        logic [2:0] e;
        logic       ea;
        logic [3:0] got;
        do_reset(4'd15);
        for (int k = 1; k <= 10; k++) begin
            step();
            e = exp_default(k);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL mid_reset_pre k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
        rst_n = 1'b0;
        step();
        got = {phi2, phi1_en, phi2_en, aux_en};
        n_total++;
        if (got !== 4'b0000)
            $display("FAIL mid_reset_zero got=%b exp=0000", got);
        else
            n_pass++;
        rst_n  = 1'b1;
        n_p2en = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            e = exp_default(k);
            aux_model(e[0], ea);
            got = {phi2, phi1_en, phi2_en, aux_en};
            n_total++;
            if (got !== {e, ea})
                $display("FAIL mid_reset_post k=%0d got=%b exp=%b", k, got, {e, ea});
            else
                n_pass++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        hold    = 1'b0;
        div_sel = 4'd15;
        test_reset();
        test_default_period();
        test_ratio_change();
        test_min_ratio();
        test_hold();
        test_reset_mid_high();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
